// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Brief    : Two-requester TX command arbiter with outstanding-read tag FIFO
//            that routes RX replies back to the scheduler or prefetch unit.
// Revision : 1.0
// ============================================================================
module tx_arbiter #(
    parameter int CMD_BITS = 2,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sched_cmd_valid,
    input  logic [CMD_BITS-1:0] sched_cmd,
    input  logic                sched_cmd_is_read,
    input  logic                sched_reserve,
    output logic                sched_started,
    input  logic                pf_cmd_valid,
    input  logic [CMD_BITS-1:0] pf_cmd,
    output logic                pf_started,
    output logic                tx_command_valid,
    output logic [CMD_BITS-1:0] tx_command,
    input  logic                tx_command_started,
    input  logic                rx_started,
    input  logic                rx_done,
    output logic                rx_to_sched,
    output logic                rx_to_pf,
    output logic [1:0]          outstanding,
    output logic                rx_unexpected
);

    localparam logic [1:0] c_DEPTH    = 2'(DEPTH);
    localparam logic [1:0] c_LAST_IDX = 2'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_S = 2'd1,
        ST_GRANT_P = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_last_grant;       // 1 = prefetch was granted last
    logic       w_last_grant_next;

    logic [3:0] r_tags;             // 0 = scheduler, 1 = prefetch
    logic [1:0] r_head;
    logic [1:0] r_tail;
    logic [1:0] r_count;
    logic       r_rx_busy;
    logic       r_rx_unexpected;

    logic       w_not_full;
    logic       w_empty;
    logic       w_cand_s;
    logic       w_cand_p;
    logic       w_push;
    logic       w_push_tag;
    logic       w_pop;
    logic       w_head_tag;
    logic       w_rx_active;

    assign w_not_full = (r_count < c_DEPTH);
    assign w_empty    = (r_count == 2'd0);
    assign w_cand_s   = sched_cmd_valid && (!sched_cmd_is_read || w_not_full);
    assign w_cand_p   = pf_cmd_valid && !sched_reserve && w_not_full;

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        tx_command_valid  = 1'b0;
        tx_command        = '0;
        sched_started     = 1'b0;
        pf_started        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cand_s && w_cand_p) begin
                    w_state_next = r_last_grant ? ST_GRANT_S : ST_GRANT_P;
                end else if (w_cand_s) begin
                    w_state_next = ST_GRANT_S;
                end else if (w_cand_p) begin
                    w_state_next = ST_GRANT_P;
                end
            end
            ST_GRANT_S: begin
                tx_command_valid = 1'b1;
                tx_command       = sched_cmd;
                sched_started    = tx_command_started;
                if (tx_command_started) begin
                    w_state_next      = ST_IDLE;
                    w_last_grant_next = 1'b0;
                end
            end
            ST_GRANT_P: begin
                tx_command_valid = 1'b1;
                tx_command       = pf_cmd;
                pf_started       = tx_command_started;
                if (tx_command_started) begin
                    w_state_next      = ST_IDLE;
                    w_last_grant_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // A push can never hit a full FIFO: read grants require free space and
    // only one grant is ever in flight.
    assign w_push     = pf_started || (sched_started && sched_cmd_is_read);
    assign w_push_tag = pf_started;
    assign w_pop      = rx_done && !w_empty;
    assign w_head_tag = r_tags[r_head];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tags  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tags[r_tail] <= w_push_tag;
                r_tail         <= (r_tail == c_LAST_IDX) ? 2'd0 : r_tail + 2'd1;
            end
            if (w_pop) begin
                r_head <= (r_head == c_LAST_IDX) ? 2'd0 : r_head + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Replies arriving with nothing outstanding are flagged and never routed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_busy       <= 1'b0;
            r_rx_unexpected <= 1'b0;
        end else begin
            if (rx_done) begin
                r_rx_busy <= 1'b0;
            end else if (rx_started && !w_empty) begin
                r_rx_busy <= 1'b1;
            end
            if ((rx_started || rx_done) && w_empty) begin
                r_rx_unexpected <= 1'b1;
            end
        end
    end

    assign w_rx_active   = r_rx_busy || (rx_started && !w_empty);
    assign rx_to_sched   = w_rx_active && !w_head_tag;
    assign rx_to_pf      = w_rx_active && w_head_tag;
    assign outstanding   = r_count;
    assign rx_unexpected = r_rx_unexpected;

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_arbiter
// Brief    : Directed self-checking bench for tx_arbiter.
// Revision : 1.0
// ============================================================================
module tb_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       sched_cmd_valid;
    logic [1:0] sched_cmd;
    logic       sched_cmd_is_read;
    logic       sched_reserve;
    logic       sched_started;
    logic       pf_cmd_valid;
    logic [1:0] pf_cmd;
    logic       pf_started;
    logic       tx_command_valid;
    logic [1:0] tx_command;
    logic       tx_command_started;
    logic       rx_started;
    logic       rx_done;
    logic       rx_to_sched;
    logic       rx_to_pf;
    logic [1:0] outstanding;
    logic       rx_unexpected;

    int n_checks = 0;
    int n_fail   = 0;

    tx_arbiter #(.CMD_BITS(2), .DEPTH(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .sched_cmd_valid    (sched_cmd_valid),
        .sched_cmd          (sched_cmd),
        .sched_cmd_is_read  (sched_cmd_is_read),
        .sched_reserve      (sched_reserve),
        .sched_started      (sched_started),
        .pf_cmd_valid       (pf_cmd_valid),
        .pf_cmd             (pf_cmd),
        .pf_started         (pf_started),
        .tx_command_valid   (tx_command_valid),
        .tx_command         (tx_command),
        .tx_command_started (tx_command_started),
        .rx_started         (rx_started),
        .rx_done            (rx_done),
        .rx_to_sched        (rx_to_sched),
        .rx_to_pf           (rx_to_pf),
        .outstanding        (outstanding),
        .rx_unexpected      (rx_unexpected)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sched_cmd_valid    = 1'b0;
        sched_cmd          = 2'b00;
        sched_cmd_is_read  = 1'b0;
        sched_reserve      = 1'b0;
        pf_cmd_valid       = 1'b0;
        pf_cmd             = 2'b00;
        tx_command_started = 1'b0;
        rx_started         = 1'b0;
        rx_done            = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (tx_command_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", tx_command_valid); end
        n_checks++; if (tx_command !== 2'b00) begin n_fail++; $display("FAIL reset_cmd: got %b want 00", tx_command); end
        n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        n_checks++; if (rx_unexpected !== 1'b0) begin n_fail++; $display("FAIL reset_unexpected: got %b want 0", rx_unexpected); end
        n_checks++; if ({sched_started, pf_started, rx_to_sched, rx_to_pf} !== 4'b0000) begin n_fail++; $display("FAIL reset_misc: got %b want 0000", {sched_started, pf_started, rx_to_sched, rx_to_pf}); end
    endtask

    task automatic test_sched_read();
        apply_reset();
        sched_cmd_valid = 1'b1; sched_cmd_is_read = 1'b1; sched_cmd = 2'b01;
        #1;
        n_checks++; if (tx_command_valid !== 1'b0) begin n_fail++; $display("FAIL sr_idle_valid: got %b want 0", tx_command_valid); end
        tick();
        n_checks++; if (tx_command_valid !== 1'b1) begin n_fail++; $display("FAIL sr_grant_valid: got %b want 1", tx_command_valid); end
        n_checks++; if (tx_command !== 2'b01) begin n_fail++; $display("FAIL sr_grant_cmd: got %b want 01", tx_command); end
        n_checks++; if (sched_started !== 1'b0) begin n_fail++; $display("FAIL sr_early_start: got %b want 0", sched_started); end
        tx_command_started = 1'b1;
        #1;
        n_checks++; if ({sched_started, pf_started} !== 2'b10) begin n_fail++; $display("FAIL sr_started: got %b want 10", {sched_started, pf_started}); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (tx_command_valid !== 1'b0) begin n_fail++; $display("FAIL sr_back_idle: got %b want 0", tx_command_valid); end
        n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL sr_outstanding: got %0d want 1", outstanding); end
    endtask

    task automatic test_alternate();
        logic       exp_v;
        logic       exp_s;
        logic       exp_p;
        apply_reset();
        sched_cmd_valid = 1'b1; sched_cmd_is_read = 1'b0; sched_cmd = 2'b10;
        pf_cmd_valid = 1'b1; pf_cmd = 2'b11;
        tx_command_started = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_v = (k % 2) == 1;
            exp_s = (k == 1) || (k == 5);
            exp_p = (k == 3) || (k == 7);
            n_checks++; if (tx_command_valid !== exp_v) begin n_fail++; $display("FAIL alt_valid[%0d]: got %b want %b", k, tx_command_valid, exp_v); end
            n_checks++; if ({sched_started, pf_started} !== {exp_s, exp_p}) begin n_fail++; $display("FAIL alt_started[%0d]: got %b want %b", k, {sched_started, pf_started}, {exp_s, exp_p}); end
            if (exp_v) begin
                n_checks++; if (tx_command !== (exp_s ? 2'b10 : 2'b11)) begin n_fail++; $display("FAIL alt_cmd[%0d]: got %b want %b", k, tx_command, exp_s ? 2'b10 : 2'b11); end
            end
            tick();
        end
        clear_inputs();
        #1;
        n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL alt_outstanding: got %0d want 2", outstanding); end
    endtask

    task automatic test_reserve_full();
        apply_reset();
        pf_cmd_valid = 1'b1; pf_cmd = 2'b01; sched_reserve = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (tx_command_valid !== 1'b0) begin n_fail++; $display("FAIL rsv_block[%0d]: got %b want 0", k, tx_command_valid); end
            tick();
        end
        sched_reserve = 1'b0;
        tick();
        n_checks++; if (tx_command_valid !== 1'b1 || tx_command !== 2'b01) begin n_fail++; $display("FAIL rsv_grant: got %b/%b want 1/01", tx_command_valid, tx_command); end
        sched_reserve = 1'b1;
        tick();
        n_checks++; if (tx_command_valid !== 1'b1) begin n_fail++; $display("FAIL rsv_no_revoke: got %b want 1", tx_command_valid); end
        sched_reserve = 1'b0; tx_command_started = 1'b1;
        #1;
        n_checks++; if (pf_started !== 1'b1) begin n_fail++; $display("FAIL rsv_pf_started: got %b want 1", pf_started); end
        tick();
        tx_command_started = 1'b0;
        tick();
        tx_command_started = 1'b1;
        tick();
        tx_command_started = 1'b0;
        n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d want 2", outstanding); end
        tick();
        n_checks++; if (tx_command_valid !== 1'b0) begin n_fail++; $display("FAIL full_pf_block: got %b want 0", tx_command_valid); end
        sched_cmd_valid = 1'b1; sched_cmd_is_read = 1'b1; sched_cmd = 2'b10;
        tick();
        n_checks++; if (tx_command_valid !== 1'b0) begin n_fail++; $display("FAIL full_sread_block: got %b want 0", tx_command_valid); end
        sched_cmd_is_read = 1'b0;
        tick();
        n_checks++; if (tx_command_valid !== 1'b1 || tx_command !== 2'b10) begin n_fail++; $display("FAIL full_swrite_grant: got %b/%b want 1/10", tx_command_valid, tx_command); end
        tx_command_started = 1'b1;
        #1;
        n_checks++; if ({sched_started, pf_started} !== 2'b10) begin n_fail++; $display("FAIL full_swrite_started: got %b want 10", {sched_started, pf_started}); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL full_write_nopush: got %0d want 2", outstanding); end
    endtask

    task automatic test_routing();
        apply_reset();
        pf_cmd_valid = 1'b1; pf_cmd = 2'b11;
        tick();
        tx_command_started = 1'b1;
        tick();
        clear_inputs();
        sched_cmd_valid = 1'b1; sched_cmd_is_read = 1'b1; sched_cmd = 2'b01;
        tick();
        tx_command_started = 1'b1;
        tick();
        clear_inputs();
        #1;
        n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL rt_count2: got %0d want 2", outstanding); end
        n_checks++; if ({rx_to_sched, rx_to_pf} !== 2'b00) begin n_fail++; $display("FAIL rt_quiet: got %b want 00", {rx_to_sched, rx_to_pf}); end
        rx_started = 1'b1;
        #1;
        n_checks++; if ({rx_to_sched, rx_to_pf} !== 2'b01) begin n_fail++; $display("FAIL rt1_start: got %b want 01", {rx_to_sched, rx_to_pf}); end
        tick();
        rx_started = 1'b0;
        #1;
        n_checks++; if ({rx_to_sched, rx_to_pf} !== 2'b01) begin n_fail++; $display("FAIL rt1_mid: got %b want 01", {rx_to_sched, rx_to_pf}); end
        rx_done = 1'b1;
        #1;
        n_checks++; if ({rx_to_sched, rx_to_pf} !== 2'b01) begin n_fail++; $display("FAIL rt1_done: got %b want 01", {rx_to_sched, rx_to_pf}); end
        tick();
        rx_done = 1'b0;
        #1;
        n_checks++; if ({rx_to_sched, rx_to_pf} !== 2'b00) begin n_fail++; $display("FAIL rt1_after: got %b want 00", {rx_to_sched, rx_to_pf}); end
        n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL rt_count1: got %0d want 1", outstanding); end
        rx_started = 1'b1; rx_done = 1'b1;
        #1;
        n_checks++; if ({rx_to_sched, rx_to_pf} !== 2'b10) begin n_fail++; $display("FAIL rt2_sched: got %b want 10", {rx_to_sched, rx_to_pf}); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rt_count0: got %0d want 0", outstanding); end
        n_checks++; if ({rx_to_sched, rx_to_pf, rx_unexpected} !== 3'b000) begin n_fail++; $display("FAIL rt2_after: got %b want 000", {rx_to_sched, rx_to_pf, rx_unexpected}); end
        pf_cmd_valid = 1'b1; pf_cmd = 2'b10;
        tick();
        tx_command_started = 1'b1;
        tick();
        tx_command_started = 1'b0;
        pf_cmd_valid = 1'b0;
        tick();
        pf_cmd_valid = 1'b1;
        tick();
        tx_command_started = 1'b1; rx_started = 1'b1; rx_done = 1'b1;
        #1;
        n_checks++; if ({rx_to_sched, rx_to_pf, pf_started} !== 3'b011) begin n_fail++; $display("FAIL rt3_pushpop: got %b want 011", {rx_to_sched, rx_to_pf, pf_started}); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL rt_pushpop_count: got %0d want 1", outstanding); end
        rx_started = 1'b1; rx_done = 1'b1;
        #1;
        n_checks++; if ({rx_to_sched, rx_to_pf} !== 2'b01) begin n_fail++; $display("FAIL rt4_pf: got %b want 01", {rx_to_sched, rx_to_pf}); end
        tick();
        clear_inputs();
        #1;
        n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rt4_count: got %0d want 0", outstanding); end
    endtask

    task automatic test_error_reset();
        apply_reset();
        rx_started = 1'b1;
        #1;
        n_checks++; if ({rx_to_sched, rx_to_pf} !== 2'b00) begin n_fail++; $display("FAIL err_noroute: got %b want 00", {rx_to_sched, rx_to_pf}); end
        tick();
        rx_started = 1'b0;
        #1;
        n_checks++; if (rx_unexpected !== 1'b1 || outstanding !== 2'd0) begin n_fail++; $display("FAIL err_start: got %b/%0d want 1/0", rx_unexpected, outstanding); end
        tick(); tick(); tick();
        n_checks++; if (rx_unexpected !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", rx_unexpected); end
        apply_reset();
        #1;
        n_checks++; if (rx_unexpected !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", rx_unexpected); end
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        #1;
        n_checks++; if (rx_unexpected !== 1'b1 || outstanding !== 2'd0) begin n_fail++; $display("FAIL err_done: got %b/%0d want 1/0", rx_unexpected, outstanding); end
        pf_cmd_valid = 1'b1; pf_cmd = 2'b11;
        tick();
        tx_command_started = 1'b1;
        tick();
        tx_command_started = 1'b0;
        tick();
        n_checks++; if (tx_command_valid !== 1'b1 || outstanding !== 2'd1) begin n_fail++; $display("FAIL rg_pre: got %b/%0d want 1/1", tx_command_valid, outstanding); end
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if ({tx_command_valid, tx_command, sched_started, pf_started} !== 5'b00000) begin n_fail++; $display("FAIL rg_tx: got %b want 00000", {tx_command_valid, tx_command, sched_started, pf_started}); end
        n_checks++; if ({rx_to_sched, rx_to_pf, outstanding, rx_unexpected} !== 5'b00000) begin n_fail++; $display("FAIL rg_rx: got %b want 00000", {rx_to_sched, rx_to_pf, outstanding, rx_unexpected}); end
        tick();
        n_checks++; if (tx_command_valid !== 1'b0) begin n_fail++; $display("FAIL rg_abandoned: got %b want 0", tx_command_valid); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_sched_read();
        test_alternate();
        test_reserve_full();
        test_routing();
        test_error_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameters: CMD_BITS, default 2, TX command header width; DEPTH, default 2, maximum number of outstanding reads (1..3).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- sched_cmd_valid  in  1  scheduler command request
- sched_cmd  in  CMD_BITS  scheduler command header
- sched_cmd_is_read  in  1  scheduler command expects an RX reply
- sched_reserve  in  1  scheduler claims TX; blocks new prefetch grants
- sched_started  out  1  scheduler command accepted by TX
- pf_cmd_valid  in  1  prefetch read request
- pf_cmd  in  CMD_BITS  prefetch command header, always a read
- pf_started  out  1  prefetch command accepted by TX
- tx_command_valid  out  1  command offered to TX
- tx_command  out  CMD_BITS  offered header
- tx_command_started  in  1  TX accepted the offered command
- rx_started  in  1  first cycle of an RX reply
- rx_done  in  1  last cycle of an RX reply
- rx_to_sched  out  1  current RX reply belongs to scheduler
- rx_to_pf  out  1  current RX reply belongs to prefetch
- outstanding  out  2  number of reads awaiting reply
- rx_unexpected  out  1  sticky error flag

Function
REQ-003 SHALL implement FSM states IDLE, GRANT_S, GRANT_P.
REQ-004 IDLE: candidate_s = sched_cmd_valid && (!sched_cmd_is_read || outstanding < DEPTH); candidate_p = pf_cmd_valid && !sched_reserve && outstanding < DEPTH.
REQ-005 IDLE, one candidate -> GRANT of that requester next cycle.
REQ-006 IDLE, both candidates -> grant the requester not granted last (last_grant bit); last_grant resets to prefetch, so scheduler wins first tie.
REQ-007 IDLE, no candidate -> stay IDLE.
REQ-008 In GRANT_S/GRANT_P, tx_command_valid SHALL be 1 and tx_command SHALL equal the granted requester's header; in IDLE, tx_command_valid = 0 and tx_command = 0.
REQ-009 Requester SHALL hold valid and header stable from request until its started pulse; arbiter behaviour is undefined otherwise.
REQ-010 sched_started = tx_command_started && state==GRANT_S; pf_started = tx_command_started && state==GRANT_P; both combinational, one cycle.
REQ-011 On tx_command_started in a GRANT state -> IDLE next cycle; last_grant updated; minimum issue spacing is 2 cycles.
REQ-012 A grant already in progress SHALL NOT be revoked by a later sched_reserve.
REQ-013 tx_command_started while IDLE SHALL be ignored, with no state or FIFO change.
REQ-014 Outstanding-read tag FIFO, DEPTH entries, tag 0=scheduler, 1=prefetch.
- Push on an accepted read: pf start, or sched start with sched_cmd_is_read.
- Pop on rx_done.
REQ-015 outstanding SHALL equal FIFO occupancy; simultaneous push and pop leave the count unchanged, head advances, and the tail is written.
REQ-016 Reply-in-progress flag: set on rx_started, cleared on rx_done; rx_started && rx_done in the same cycle leaves it clear.
REQ-017 rx_to_sched / rx_to_pf SHALL be high from the rx_started cycle through the rx_done cycle inclusive, selected by the head tag; both 0 otherwise.
REQ-018 rx_started with outstanding==0 SHALL set rx_unexpected, with no routing and no pop.
REQ-019 rx_done with outstanding==0 SHALL set rx_unexpected, with no pop.
REQ-020 rx_unexpected SHALL clear only on reset.
REQ-021 A full FIFO SHALL block read grants only; scheduler writes may still be granted.

Reset
REQ-022 When reset is high at a clock edge, the following SHALL hold after that edge regardless of state:
- state IDLE, last_grant = prefetch
- FIFO empty, outstanding 0, reply flag 0, rx_unexpected 0
- all outputs 0
REQ-023 Reset SHALL abandon a command granted but not started, and drop all pending tags.

Verification
REQ-024 Scheduler read alone: sched_cmd_valid=1, is_read=1, cmd=2'b01.
- Next cycle: tx_command_valid=1, tx_command=01.
- Then started -> sched_started pulse; outstanding=1; IDLE.
REQ-025 Simultaneous requests after reset, both valid every cycle:
- Grants alternate S,P,S,P.
- Command accepts at cycles 1,3,5,7 (1-cycle started).
REQ-026 Reserve and full FIFO:
- sched_reserve=1 with pf valid -> no pf grant.
- With outstanding=2, a sched write (is_read=0) is granted; a sched read is not.
REQ-027 Routing with tags [P,S]:
- First RX reply -> rx_to_pf high rx_started..rx_done.
- Second reply -> rx_to_sched; outstanding 2->1->0.
- Push coinciding with rx_done keeps outstanding constant.
REQ-028 Error and reset:
- rx_started with outstanding=0 -> rx_unexpected=1, sticky.
- Reset in GRANT_P -> next cycle all outputs 0, outstanding 0, rx_unexpected 0.
